sha256_msg_padder: RTL

- Upstream front end of the SHA-256 compression core.
- Accepts an arbitrary-length byte message as a stream of big-endian 32-bit words with a valid/ready handshake.
- Emits complete 512-bit message blocks with FIPS 180-4 padding applied: a 0x80 byte, zero fill, and a 64-bit big-endian bit length.
- blk_last marks the final block of a message so the core knows when to finalise the digest.

---
 rtl/sha256_msg_padder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit bit length of the whole message.
module sha256_msg_padder #(
    parameter int LEN_CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    typedef enum logic {FILL, EMIT} state_t;

    state_t               state_reg, state_next;
    logic [31:0]          buf_reg [16];
    logic [31:0]          buf_next [16];
    logic [3:0]           widx_reg;
    logic [LEN_CNT_W-1:0] byte_cnt_reg;
    logic                 extra_pend_reg;
    logic                 extra_mark_reg;
    logic                 blk_last_reg;

    logic                 in_fire;
    logic                 blk_fire;
    logic [2:0]           eff_n;
    logic [LEN_CNT_W-1:0] cnt_sum;
    logic [63:0]          len_fill;
    logic [63:0]          len_cur;
    logic [6:0]           mark_pos;
    logic                 fits_len;
    logic                 pure_data;
    logic [31:0]          last_word;

    // Out-of-range byte counts, and any count on a non-final word, act as a full word.
    assign eff_n     = (in_last && in_nbytes < 3'd4) ? in_nbytes : 3'd4;
    assign cnt_sum   = byte_cnt_reg + LEN_CNT_W'(eff_n);
    assign len_fill  = 64'({cnt_sum, 3'b000});
    assign len_cur   = 64'({byte_cnt_reg, 3'b000});
    assign mark_pos  = {1'b0, widx_reg, 2'b00} + 7'(eff_n);
    assign fits_len  = (mark_pos <= 7'd55);
    assign pure_data = (mark_pos == 7'd64);

    assign in_ready  = (state_reg == FILL) && !rst;
    assign blk_valid = (state_reg == EMIT) && !rst;
    assign blk_last  = blk_last_reg && !rst;
    assign in_fire   = in_valid && in_ready;
    assign blk_fire  = blk_valid && blk_ready;

    always_comb begin
        last_word = in_data;
        case (eff_n)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {in_data[31:24], 24'h80_0000};
            3'd2:    last_word = {in_data[31:16], 16'h8000};
            3'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            logic [31:0] fin_val;
            logic [31:0] extra_val;

            // Final word: keep earlier data, place marker, and zero everything above it.
            assign fin_val =
                (4'(gi) < widx_reg)                          ? buf_reg[gi] :
                (4'(gi) == widx_reg)                         ? last_word :
                ((5'(gi) == 5'(widx_reg) + 5'd1) && eff_n == 3'd4) ? 32'h8000_0000 :
                (fits_len && gi == 14)                       ? len_fill[63:32] :
                (fits_len && gi == 15)                       ? len_fill[31:0] :
                                                               32'h0;

            assign extra_val =
                (gi == 0)  ? (extra_mark_reg ? 32'h8000_0000 : 32'h0) :
                (gi == 14) ? len_cur[63:32] :
                (gi == 15) ? len_cur[31:0] :
                             32'h0;

            assign buf_next[gi] =
                in_fire ? (in_last ? fin_val : ((4'(gi) == widx_reg) ? in_data : buf_reg[gi])) :
                (blk_fire && extra_pend_reg) ? extra_val :
                buf_reg[gi];

            assign blk_data[511-32*gi -: 32] = rst ? 32'h0 : buf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            buf_reg[i] <= rst ? 32'h0 : buf_next[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: if (in_fire && (in_last || widx_reg == 4'd15)) state_next = EMIT;
            EMIT: if (blk_fire && !extra_pend_reg) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            widx_reg       <= 4'd0;
            byte_cnt_reg   <= '0;
            extra_pend_reg <= 1'b0;
            extra_mark_reg <= 1'b0;
            blk_last_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (in_fire) begin
                byte_cnt_reg <= cnt_sum;
                if (in_last) begin
                    widx_reg       <= 4'd0;
                    blk_last_reg   <= fits_len;
                    extra_pend_reg <= !fits_len;
                    extra_mark_reg <= pure_data;
                end else begin
                    widx_reg <= widx_reg + 4'd1;
                end
            end
            if (blk_fire) begin
                if (extra_pend_reg) begin
                    extra_pend_reg <= 1'b0;
                    blk_last_reg   <= 1'b1;
                end else if (blk_last_reg) begin
                    byte_cnt_reg <= '0;
                    blk_last_reg <= 1'b0;
                end
            end
        end
    end

endmodule
